// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: size encodings, FSM states and defaults shared by the load/store unit.
package load_store_unit_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int MEM_WORDS_DEF = 128;
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_WR, RESP} state_t;
endpackage

// File: rtl/load_store_unit_lane_formatter.sv
// lsu_lane_formatter: little-endian lane extraction with sign/zero extension for loads,
// and lane merge of a store operand into a read word for sub-word stores.
module lsu_lane_formatter
  import load_store_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] operand,
  output logic [31:0] load_val,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = 8'(word >> {lane, 3'b000});
  assign h = 16'(word >> {lane[1], 4'b0000});
  assign load_val = size == SZ_BYTE ? {{24{b[7] & ~is_unsigned}}, b}
                  : size == SZ_HALF ? {{16{h[15] & ~is_unsigned}}, h} : word;
  assign merged = size == SZ_BYTE
                ? (word & ~(32'h0000_00FF << {lane, 3'b000})) | (32'(operand[7:0]) << {lane, 3'b000})
                : size == SZ_HALF
                ? (word & ~(32'h0000_FFFF << {lane[1], 4'b0000})) | (32'(operand[15:0]) << {lane[1], 4'b0000})
                : operand;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle byte/half/word load/store to word-addressed memory,
// sub-word stores via read-modify-write, bad requests faulted before any access.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        load,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_read_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);
  state_t      state, state_nx;
  logic [1:0]  lane_q, size_q;
  logic        uns_q, ld_q, flt_q, bad;
  logic [31:0] fmt_load, fmt_merge;
  assign bad = (load == store) || size == 2'b11 || (size == SZ_HALF && addr[0])
            || (size == SZ_WORD && addr[1:0] != 2'b00)
            || ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
  lsu_lane_formatter u_fmt (
    .word        (mem_read_data),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .operand     (mem_write_data),
    .load_val    (fmt_load),
    .merged      (fmt_merge)
  );
  always_comb begin
    state_nx = IDLE;
    if (state == IDLE)
      state_nx = !start ? IDLE : bad ? RESP : (load || size != SZ_WORD) ? RD : WR;
    else if (state == RD)
      state_nx = ld_q ? RESP : RMW_WR;
    else if (state == WR || state == RMW_WR)
      state_nx = RESP;
    mem_read  = state == RD;
    mem_write = state == WR || state == RMW_WR;
    busy      = state != IDLE;
    done      = state == RESP;
    fault     = state == RESP && flt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      mem_addr       <= '0;
      mem_write_data <= '0;
      load_data      <= '0;
      lane_q         <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      ld_q           <= 1'b0;
      flt_q          <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        mem_addr       <= {2'b00, addr[31:2]};
        mem_write_data <= store_data;
        lane_q         <= addr[1:0];
        size_q         <= size;
        uns_q          <= is_unsigned;
        ld_q           <= load;
        flt_q          <= bad;
      end
      // the store operand register becomes the merged word for the RMW write
      if (state == RD && ld_q) load_data <= fmt_load;
      if (state == RD && !ld_q) mem_write_data <= fmt_merge;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table driven through a scoreboard queue, plus reset-in-RD
// and start-while-busy sequences, against a falling-edge data memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;
  typedef struct {
    logic        ld, st;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] addr, sd;
    logic        e_flt;
    logic [31:0] e_ld;
    int          e_lat, e_rd, e_wr;
    logic [31:0] e_widx, e_wdata;
  } vec_t;
  logic        clk = 0, rst_n = 0, start = 0, load = 0, store = 0, is_unsigned = 0;
  logic [1:0]  size = 0;
  logic [31:0] addr = 0, store_data = 0, mem_read_data = 0;
  logic [31:0] mem_addr, mem_write_data, load_data;
  logic        mem_read, mem_write, busy, done, fault, mem_ok = 0;
  logic [31:0] mem [128];
  int          cyc = 0, total = 0, bad = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, start_cyc = 0, d0;
  vec_t        exp_q[$];
  vec_t        tbl[$];
  vec_t        mon_e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  load_store_unit #(.MEM_WORDS(128)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load(load), .store(store), .size(size),
    .is_unsigned(is_unsigned), .addr(addr), .store_data(store_data),
    .mem_read_data(mem_read_data), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .load_data(load_data), .busy(busy),
    .done(done), .fault(fault)
  );
  always @(negedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem[2] <= 32'h80FF7F51;
      mem_ok <= 1'b1;
    end else begin
      if (mem_write && mem_addr < 128) mem[mem_addr[6:0]] <= mem_write_data;
      if (mem_read && mem_addr < 128) mem_read_data <= mem[mem_addr[6:0]];
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, expv);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read && mem_write) chk("rd_wr_both", 1, 0);
      if (mem_read) rd_cnt++;
      if (mem_write) begin
        wr_cnt++;
        if (exp_q.size() > 0) begin
          chk("wr_idx", mem_addr, exp_q[0].e_widx);
          chk("wr_data", mem_write_data, exp_q[0].e_wdata);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("fault", {31'b0, fault}, {31'b0, mon_e.e_flt});
          chk("load_data", load_data, mon_e.e_ld);
          chk("latency", cyc - start_cyc, mon_e.e_lat);
          chk("reads", rd_cnt, mon_e.e_rd);
          chk("writes", wr_cnt, mon_e.e_wr);
          chk("busy_resp", {31'b0, busy}, 1);
        end
        rd_cnt = 0;
        wr_cnt = 0;
        done_cnt++;
      end
    end
  end
  function automatic vec_t mk(input logic ld, input logic st, input logic [1:0] sz,
                              input logic un, input logic [31:0] a, input logic [31:0] d,
                              input logic f, input logic [31:0] el, input int lat,
                              input int rd, input int wr, input logic [31:0] wi,
                              input logic [31:0] wd);
    vec_t v;
    v.ld = ld; v.st = st; v.sz = sz; v.un = un; v.addr = a; v.sd = d;
    v.e_flt = f; v.e_ld = el; v.e_lat = lat; v.e_rd = rd; v.e_wr = wr;
    v.e_widx = wi; v.e_wdata = wd;
    return v;
  endfunction
  task automatic req(input vec_t v, input bit poke);
    int tgt, t;
    @(negedge clk);
    load = v.ld; store = v.st; size = v.sz; is_unsigned = v.un;
    addr = v.addr; store_data = v.sd; start = 1;
    start_cyc = cyc;
    exp_q.push_back(v);
    tgt = done_cnt + 1;
    @(negedge clk); #1;
    if (poke) begin
      load = 1; store = 0; size = SZ_WORD; addr = 32'h8;
    end else start = 0;
    t = 0;
    while (done_cnt < tgt && t < 8) begin
      @(negedge clk); #1;
      t++;
    end
    start = 0;
    if (done_cnt < tgt) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask
  initial begin
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h8,   0, 0, 32'h80FF7F51, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_BYTE, 0, 32'hB,   0, 0, 32'hFFFFFF80, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_BYTE, 1, 32'hB,   0, 0, 32'h00000080, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_HALF, 0, 32'hA,   0, 0, 32'hFFFF80FF, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_HALF, 1, 32'hA,   0, 0, 32'h000080FF, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h6,   0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h200, 0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, SZ_WORD, 0, 32'h8,   0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, SZ_WORD, 0, 32'h8,   0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 2'b11,   0, 32'h8,   0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_HALF, 0, 32'h9,   0, 1, 32'h000080FF, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, SZ_BYTE, 0, 32'h9, 32'h123456AB, 0, 32'h000080FF, 3, 1, 1, 2, 32'h80FFAB51));
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h8,   0, 0, 32'h80FFAB51, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, SZ_WORD, 0, 32'h8, 32'h80FF7F51, 0, 32'h80FFAB51, 2, 0, 1, 2, 32'h80FF7F51));
    tbl.push_back(mk(0, 1, SZ_HALF, 0, 32'hA, 32'h0000BEEF, 0, 32'h80FFAB51, 3, 1, 1, 2, 32'hBEEF7F51));
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h8,   0, 0, 32'hBEEF7F51, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_HALF, 0, 32'h8,   0, 0, 32'h00007F51, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_BYTE, 0, 32'h9,   0, 0, 32'h0000007F, 2, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, SZ_WORD, 0, 32'h1FC, 32'h11223344, 0, 32'h0000007F, 2, 0, 1, 127, 32'h11223344));
    tbl.push_back(mk(1, 0, SZ_WORD, 0, 32'h1FC, 0, 0, 32'h11223344, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, SZ_BYTE, 1, 32'h1FD, 0, 0, 32'h00000033, 2, 1, 0, 0, 0));
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_mem_read", {31'b0, mem_read}, 0);
    chk("rst_mem_write", {31'b0, mem_write}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_fault", {31'b0, fault}, 0);
    #1 rst_n = 1;
    foreach (tbl[i]) req(tbl[i], 0);
    @(negedge clk);
    load = 1; store = 0; size = SZ_WORD; is_unsigned = 0; addr = 32'h8; start = 1;
    @(negedge clk);
    start = 0;
    chk("rd_before_reset", {31'b0, mem_read}, 1);
    #2 rst_n = 0;
    #1;
    chk("reset_mem_read", {31'b0, mem_read}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_done", {31'b0, done}, 0);
    chk("reset_load_data", load_data, 0);
    chk("reset_mem_addr", mem_addr, 0);
    @(negedge clk); #1 rst_n = 1;
    req(mk(0, 1, SZ_WORD, 0, 32'h4, 32'hDEADBEEF, 0, 32'h0, 2, 0, 1, 1, 32'hDEADBEEF), 1);
    d0 = done_cnt;
    repeat (4) @(negedge clk);
    #1;
    chk("no_queued_start", done_cnt, d0);
    chk("idle_after_poke", {31'b0, busy}, 0);
    req(mk(1, 0, SZ_WORD, 0, 32'h4, 0, 0, 32'hDEADBEEF, 2, 1, 0, 0, 0), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage (ALU address result plus store operand) and the word-addressed data memory. It converts byte addresses to word indices and performs byte/halfword/word loads with sign or zero extension. Sub-word stores are done as a read-modify-write sequence. Misaligned and out-of-range requests are rejected with a fault before any memory access. The data memory samples on the falling clock edge and registers its read data at that edge, so its read data is valid at the next rising edge.

## Interface
Parameters:
- MEM_WORDS, 128, number of 32-bit words in data memory; legal word index is 0..MEM_WORDS-1.

Ports:
- Clock  in  1  single clock; all unit state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Load  in  1  request is a load.
- Store  in  1  request is a store.
- Size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- Addr  in  32  byte address from the ALU.
- StoreData  in  32  store operand; the low byte or low half is used for sub-word stores.
- MemReadData  in  32  data-memory read data.
- MemAddr  out  32  word index to data memory, {2'b00, Addr[31:2]}.
- MemWriteData  out  32  word to write.
- MemRead  out  1  data-memory read enable.
- MemWrite  out  1  data-memory write enable.
- LoadData  out  32  formatted load result; held until the next load completes.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Fault  out  1  qualifies Done: the request was rejected.

## Operation
- States: IDLE, RD, WR, RMW_WR, RESP.
- IDLE:
  - Start=1 with a valid request: capture Addr, Size, Unsigned, Load/Store and StoreData.
  - Next state: load → RD; word store → WR; sub-word store → RD with the RMW flag set.
- A request is invalid, and goes to RESP with the fault latched, when any of these holds:
  - Load and Store are both 1, or both 0.
  - Size is 11.
  - Size is half and Addr[0] is 1.
  - Size is word and Addr[1:0] is nonzero.
  - Addr[31:2] is greater than or equal to MEM_WORDS.
- RD:
  - MemRead=1.
  - At the rising edge, capture MemReadData.
  - Load: format the data into LoadData, then go to RESP.
  - RMW: merge the StoreData lane into the captured word (byte lane Addr[1:0], half lane Addr[1]), then go to RMW_WR.
- WR and RMW_WR: MemWrite=1 with MemWriteData stable for the whole cycle; then go to RESP.
- RESP: Done=1, and Fault=1 if the request was rejected; then go to IDLE.
- Byte lanes are little-endian: byte 0 is bits [7:0].
- MemRead, MemWrite and Done are decoded from the state register only, with no input-to-output paths. MemRead and MemWrite are never both 1.
- MemAddr and MemWriteData come from captured registers and do not follow the live inputs.
- Start while Busy is ignored and is not queued.
- Faulted requests never assert MemRead or MemWrite, and leave LoadData unchanged.

## Timing
- Request presented in cycle n:
  - Load: Done in cycle n+2.
  - Word store: Done in cycle n+2.
  - Sub-word store: Done in cycle n+3.
  - Fault: Done in cycle n+1.
- The next request can be accepted in the cycle after Done. Back-to-back throughput is one access per 3 cycles (4 for a sub-word store).
- Reset values: MemAddr, MemWriteData and LoadData are 0. MemRead, MemWrite, Busy, Done and Fault are 0. State is IDLE.
- Reset asserted mid-operation: all outputs take their reset values immediately. A write in progress is dropped.

## Structure
- Shared package holds:
  - Size encodings: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - The state enum.
  - The default value for MEM_WORDS.
- One combinational sub-module, lsu_lane_formatter, shared by the load and store paths:
  - Load direction: lane extraction plus sign/zero extension.
  - Store direction: lane merge.

## Test plan
- Reset with Reset=0 while the unit is in RD: MemRead=0, Busy=0, Done=0 and LoadData=0 in the same cycle.
- LW Addr=0x8, mem[2]=0x80FF7F51: MemAddr=2, MemRead for one cycle, LoadData=0x80FF7F51, Done at n+2.
- Sub-word loads, mem[2]=0x80FF7F51:
  - LB Addr=0xB gives 0xFFFFFF80; LBU Addr=0xB gives 0x00000080.
  - LH Addr=0xA gives 0xFFFF80FF; LHU Addr=0xA gives 0x000080FF.
- SB StoreData=0x123456AB, Addr=0x9, mem[2]=0x80FF7F51:
  - MemRead at n+1, then MemWrite of 0x80FFAB51 to index 2 at n+2, Done at n+3.
  - SH 0xBEEF at Addr=0xA gives 0xBEEF7F51.
- Faults:
  - LW Addr=0x6: Done+Fault at n+1, no MemRead or MemWrite, LoadData unchanged.
  - LW Addr=0x200 (index 128): Fault.
  - Load=Store=1: Fault.
- SW 0xDEADBEEF to Addr=0x4, with Start pulsed again while Busy, then LW Addr=0x4: the extra Start is ignored and the load returns 0xDEADBEEF.
